sensor_debounce: RTL and testbench

Upstream conditioning stage for the sensor error detector. It takes the raw, asynchronous sensor lines, synchronises each one into the clk domain and debounces it with its own counter. It then presents a clean, glitch-free 4-bit sensors vector to the error-detect logic. It also flags each time the stable vector changes, and reports whether any channel is still settling.

---
 rtl/sensor_pkg.sv | 13 +
 rtl/debounce_channel.sv | 92 +++++++++
 rtl/sensor_debounce.sv | 48 ++++
 tb/tb_sensor_debounce.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared types and sizing for the sensor conditioning stage.
package sensor_pkg;

  localparam int unsigned NUM_SENSORS = 4;

  typedef logic [NUM_SENSORS-1:0] sensor_vec_t;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One sensor bit: 2-flop synchroniser followed by a counting debounce FSM.
module debounce_channel
  import sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic sample_en,
  output logic level,
  output logic flip,
  output logic cnt_nz
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  deb_state_t       r_state;

  logic             w_level_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  deb_state_t       w_state_nxt;
  logic             w_flip;

  // State register, including the synchroniser flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_state <= STABLE;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_level <= w_level_nxt;
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Next-state: any sample that agrees with the accepted level aborts a pending change.
  always_comb begin
    w_level_nxt = r_level;
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_flip      = 1'b0;
    case (r_state)
      STABLE: begin
        w_cnt_nxt = '0;
        if ((r_sync2 != r_level) && sample_en) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_level_nxt = r_sync2;
            w_flip      = 1'b1;
          end else begin
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = PENDING;
          end
        end
      end
      PENDING: begin
        if (r_sync2 == r_level) begin
          w_cnt_nxt   = '0;
          w_state_nxt = STABLE;
        end else if (sample_en) begin
          if (r_cnt == CNT_LAST) begin
            w_level_nxt = r_sync2;
            w_cnt_nxt   = '0;
            w_state_nxt = STABLE;
            w_flip      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = STABLE;
      end
    endcase
  end

  assign level  = r_level;
  assign flip   = w_flip;
  assign cnt_nz = (r_cnt != '0);

endmodule

// File: rtl/sensor_debounce.sv
// Synchronise and debounce the raw sensor lines into a clean vector for error detection.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  sensor_vec_t raw_sensors,
  input  logic        sample_en,
  output sensor_vec_t sensors,
  output logic        changed,
  output logic        busy
);

  sensor_vec_t w_level;
  sensor_vec_t w_flip;
  sensor_vec_t w_cnt_nz;
  logic        r_changed;

  for (genvar g = 0; g < int'(NUM_SENSORS); g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw_sensors[g]),
      .sample_en(sample_en),
      .level    (w_level[g]),
      .flip     (w_flip[g]),
      .cnt_nz   (w_cnt_nz[g])
    );
  end

  // One pulse per edge on which any channel accepted a new level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_flip;
    end
  end

  assign sensors = w_level;
  assign changed = r_changed;
  assign busy    = |w_cnt_nz;

endmodule

// File: tb/tb_sensor_debounce.sv
// Randomised scoreboard bench for sensor_debounce against a run-length reference model.
module tb_sensor_debounce;
  import sensor_pkg::*;

  localparam int unsigned D = 8;

  logic        clk;
  logic        rst;
  sensor_vec_t raw_sensors;
  logic        sample_en;
  sensor_vec_t sensors;
  logic        changed;
  logic        busy;

  sensor_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_sensors(raw_sensors),
    .sample_en  (sample_en),
    .sensors    (sensors),
    .changed    (changed),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sensors;
    logic       changed;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference: raw reaches the logic two edges late; a level is accepted once the
  // current uninterrupted mismatch run has seen D enabled samples.
  logic [3:0] m_late0 = '0;
  logic [3:0] m_late1 = '0;
  logic [3:0] m_s     = '0;
  int         m_run[4];

  task automatic model_edge(input logic [3:0] raw, input logic en, input logic r);
    exp_t e;
    logic any_flip;
    any_flip = 1'b0;
    if (r) begin
      m_late0 = '0;
      m_late1 = '0;
      m_s     = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_late1[i] != m_s[i]) begin
          if (en) m_run[i] = m_run[i] + 1;
          if (m_run[i] >= int'(D)) begin
            m_s[i]   = ~m_s[i];
            m_run[i] = 0;
            any_flip = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_late1 = m_late0;
      m_late0 = raw;
    end
    e.sensors = m_s;
    e.changed = any_flip;
    e.busy    = 1'b0;
    for (int i = 0; i < 4; i++) if (m_run[i] != 0) e.busy = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] raw, input logic en, input logic r);
    @(negedge clk);
    raw_sensors = raw;
    sample_en   = en;
    rst         = r;
    model_edge(raw, en, r);
  endtask

  task automatic hold(input logic [3:0] raw, input logic en, input int n);
    for (int k = 0; k < n; k++) cyc(raw, en, 1'b0);
  endtask

  // Monitor: every edge presents a new output triple; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (sensors !== e.sensors) begin
          n_errors++;
          $display("FAIL sensors at %0t: got %b expected %b", $time, sensors, e.sensors);
        end
        n_checks++;
        if (changed !== e.changed) begin
          n_errors++;
          $display("FAIL changed at %0t: got %b expected %b", $time, changed, e.changed);
        end
        n_checks++;
        if (busy !== e.busy) begin
          n_errors++;
          $display("FAIL busy at %0t: got %b expected %b", $time, busy, e.busy);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    logic [3:0] rv;
    int         wait_cnt;
    raw_sensors = '0;
    sample_en   = 1'b0;
    rst         = 1'b1;
    for (int i = 0; i < 4; i++) m_run[i] = 0;

    // Reset with all lines high, then settle at zero
    cyc(4'b1111, 1'b1, 1'b1);
    cyc(4'b1111, 1'b1, 1'b1);
    hold(4'b1111, 1'b1, 1);
    hold(4'b0000, 1'b1, 16);

    // Clean step on bit2
    hold(4'b0100, 1'b1, 20);

    // Short glitch on bit0
    hold(4'b0101, 1'b1, 5);
    hold(4'b0100, 1'b1, 15);

    // Sample enable on every 4th cycle
    for (int k = 0; k < 48; k++) cyc(4'b1100, (k % 4) == 0, 1'b0);
    hold(4'b0000, 1'b1, 20);

    // Simultaneous channels, then a single bit release
    hold(4'b1011, 1'b1, 20);
    hold(4'b0011, 1'b1, 20);
    hold(4'b0000, 1'b1, 20);

    // Reset in the middle of a pending transition
    hold(4'b0010, 1'b1, 5);
    cyc(4'b0010, 1'b1, 1'b1);
    hold(4'b0010, 1'b1, 15);

    // Random toggling with run lengths straddling the debounce window
    rv = 4'b0010;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 11) == 0) rv[i] = ~rv[i];
      cyc(rv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
